mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Shares the single-port, synchronous-read framebuffer/data RAM between the CPU core (read/write) and the VGA pixel fetcher (read-only). It also decodes a small memory-mapped I/O window exposing the reset button, the x/y cursor encoders and the colour encoder to the core. It sits between CoreTop, VGA_Controller and the block RAM, and replaces the ad-hoc sharing in the current memory controller with a defined, starvation-free arbitration and handshake.

Parameters:
DATA_W, 16, data width of RAM, core and VGA buses
CORE_AW, 24, core address width
FB_AW, 15, RAM address width (RAM depth 2**FB_AW words)
MMIO_BASE, 24'h00_8000, base of 4-word I/O window (core addresses MMIO_BASE..MMIO_BASE+3)
VGA_STREAK_MAX, 4, consecutive contested VGA wins before the core is forced a grant (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
core_req  in  1  core access request
core_we  in  1  1 = write, 0 = read
core_addr  in  CORE_AW  core word address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  combinational; transfer occurs when core_req && core_gnt
core_rvalid  out  1  read data valid, exactly 1 cycle after an accepted read
core_rdata  out  DATA_W  core read data
vga_req  in  1  VGA fetch request, held until granted
vga_addr  in  FB_AW  VGA word address
vga_gnt  out  1  combinational grant to VGA
vga_rvalid  out  1  1 cycle after vga_req && vga_gnt
vga_rdata  out  DATA_W  VGA read data
mem_en, mem_we  out  1 each  RAM port controls
mem_addr  out  FB_AW  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en
io_in0..io_in3  in  DATA_W each  MMIO sources: button, x pos, y pos, colour
acc_been_read  out  1  sticky flag: core has read MMIO word 0

Behaviour:
- Reset (async assert, sync deassert assumed external): core_rvalid, vga_rvalid, acc_been_read = 0; rdata buses = 0; streak counter = 0; io sample registers = 0. In-flight reads are dropped, with no rvalid after reset.
- Core address decode, 3 classes:
  - RAM: addr < 2**FB_AW.
  - MMIO: MMIO_BASE <= addr <= MMIO_BASE+3.
  - Unmapped: everything else. Writes are discarded. Reads are accepted immediately and return 0 with normal 1-cycle latency.
- MMIO and unmapped accesses never use the RAM. core_gnt = 1 whenever core_req, and VGA may use the RAM in the same cycle.
- io_in0..3 are registered every cycle (1-cycle sample). An MMIO read returns the sampled value on the next cycle. MMIO writes are ignored, except a write to offset 0, which clears acc_been_read.
- acc_been_read sets on an accepted core read of offset 0. If a set and a clear coincide (impossible from the single core port), set wins.
- RAM arbitration, each cycle, among core (RAM class) and VGA:
  - Only one requests: it is granted.
  - Both request: VGA wins unless streak == VGA_STREAK_MAX, in which case the core wins.
- Streak counter: +1 on each contested VGA win, saturating at VGA_STREAK_MAX. Reset to 0 on any core RAM grant or on any cycle with no contention.
- Granted access drives mem_en = 1, mem_we = core_we (always 0 for VGA), mem_addr, mem_wdata. mem_en = 0 when idle.
- Read return: a 1-bit "owner" register plus a "was read" register route mem_rdata to core_rdata or vga_rdata with the matching rvalid, 1 cycle after grant. Core writes produce no rvalid.
- Non-granted rdata buses hold their last value.
- Throughput: 1 access per cycle, with back-to-back grants to either side.

Decomposition:
- Package mem_arb_pkg holds:
  - MMIO offsets (IO_BTN=0, IO_X=1, IO_Y=2, IO_COLOR=3).
  - Address-class enum {AC_RAM, AC_MMIO, AC_UNMAPPED}.
  - Pure decode function addr_class(core_addr).
- Sub-module io_reg_bank: input sampling registers, offset read mux and acc_been_read flag.
- The arbiter/streak/return pipeline stays in mem_arbiter.

Test Plan:
1. Core write 0x1234 to addr 0x0010, then read 0x0010 -> mem_we pulse at 0x0010; core_rvalid 1 cycle after read grant with core_rdata = 0x1234.
2. vga_req held high, core_req RAM reads continuous, VGA_STREAK_MAX = 4 -> grant pattern VGA,VGA,VGA,VGA,core repeating; core never waits more than 5 cycles.
3. io_in1 = 0x009F; core reads MMIO_BASE+1 while VGA reads RAM the same cycle -> both gnt = 1; core_rdata = 0x009F and vga_rdata = RAM word, both valid next cycle.
4. Core reads MMIO_BASE -> acc_been_read = 1 next cycle and stays set; core writes MMIO_BASE -> flag cleared next cycle.
5. Core write to 0x00_9000 (unmapped) -> mem_en stays 0. Core read of the same address -> core_rvalid with core_rdata = 0.
6. Assert rst_n low the cycle after a granted VGA read -> vga_rvalid stays 0; all outputs 0 and streak 0 after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the framebuffer/data RAM arbiter:
//   - MMIO word offsets inside the 4-word I/O window
//   - core address classes and a pure decode function
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

   // Word offsets inside the MMIO window
   localparam logic [1:0] IO_BTN   = 2'd0;
   localparam logic [1:0] IO_X     = 2'd1;
   localparam logic [1:0] IO_Y     = 2'd2;
   localparam logic [1:0] IO_COLOR = 2'd3;

   typedef enum logic [1:0] {
      AC_RAM,
      AC_MMIO,
      AC_UNMAPPED
   } addr_class_e;

   // Classify a (zero-extended) core word address. RAM occupies the bottom
   // 2**fb_aw words; the MMIO window is four words starting at mmio_base.
   function automatic addr_class_e addr_class(input logic [31:0] addr,
                                              input int          fb_aw,
                                              input logic [31:0] mmio_base);
      if (addr < (32'd1 << fb_aw))
         return AC_RAM;
      if ((addr >= mmio_base) && (addr <= mmio_base + 32'd3))
         return AC_MMIO;
      return AC_UNMAPPED;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the arbiter:
//   core_*  : CPU core request/grant + read return
//   vga_*   : VGA pixel fetcher request/grant + read return
//   mem_*   : single-port synchronous-read block RAM port
// modport slave  : the arbiter's view
// modport master : the surrounding system (core, VGA fetcher and RAM)
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int DATA_W  = 16,
   parameter int CORE_AW = 24,
   parameter int FB_AW   = 15
);
   logic               core_req;
   logic               core_we;
   logic [CORE_AW-1:0] core_addr;
   logic [DATA_W-1:0]  core_wdata;
   logic               core_gnt;
   logic               core_rvalid;
   logic [DATA_W-1:0]  core_rdata;

   logic               vga_req;
   logic [FB_AW-1:0]   vga_addr;
   logic               vga_gnt;
   logic               vga_rvalid;
   logic [DATA_W-1:0]  vga_rdata;

   logic               mem_en;
   logic               mem_we;
   logic [FB_AW-1:0]   mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic [DATA_W-1:0]  mem_rdata;

   modport slave (
      input  core_req, core_we, core_addr, core_wdata,
      output core_gnt, core_rvalid, core_rdata,
      input  vga_req, vga_addr,
      output vga_gnt, vga_rvalid, vga_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output core_req, core_we, core_addr, core_wdata,
      input  core_gnt, core_rvalid, core_rdata,
      output vga_req, vga_addr,
      input  vga_gnt, vga_rvalid, vga_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter_io_reg_bank.sv
// ---------------------------------------------------------------------------
// io_reg_bank
// Samples the four MMIO sources every cycle, muxes the addressed sample for
// a core read, and keeps the sticky acc_been_read flag.
// Ports:
//   clk, rst_n   clock / async active-low reset
//   i_io_in0..3  button, x pos, y pos, colour sources
//   i_rd         accepted core read of the MMIO window this cycle
//   i_wr         accepted core write of the MMIO window this cycle
//   i_offset     word offset inside the window
//   o_rdata      sampled value at i_offset (combinational)
//   o_acc        acc_been_read flag
// ---------------------------------------------------------------------------
module io_reg_bank
   import mem_arb_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_io_in0,
   input  logic [DATA_W-1:0] i_io_in1,
   input  logic [DATA_W-1:0] i_io_in2,
   input  logic [DATA_W-1:0] i_io_in3,
   input  logic              i_rd,
   input  logic              i_wr,
   input  logic [1:0]        i_offset,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_acc
);

   logic [DATA_W-1:0] r_sample [0:3];
   logic              r_acc;

   // NOTE: these four words are ordinary flops, not a RAM macro, so they are
   // reset; a real memory array would be left unreset and initialised by use.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) r_sample[i] <= '0;
      end else begin
         r_sample[0] <= i_io_in0;
         r_sample[1] <= i_io_in1;
         r_sample[2] <= i_io_in2;
         r_sample[3] <= i_io_in3;
      end
   end

   // Set has priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_acc <= 1'b0;
      else if (i_rd && (i_offset == IO_BTN))
         r_acc <= 1'b1;
      else if (i_wr && (i_offset == IO_BTN))
         r_acc <= 1'b0;
   end

   // NOTE: o_rdata gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      o_rdata = '0;
      case (i_offset)
         IO_BTN:   o_rdata = r_sample[0];
         IO_X:     o_rdata = r_sample[1];
         IO_Y:     o_rdata = r_sample[2];
         IO_COLOR: o_rdata = r_sample[3];
         default:  o_rdata = '0;
      endcase
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port synchronous-read RAM between the CPU core and the
// VGA fetcher with a bounded-starvation priority scheme, and decodes the
// 4-word MMIO window for the core.
// Ports:
//   clk, rst_n     clock / async active-low reset
//   bus            mem_arbiter_if.slave (core, VGA and RAM buses)
//   io_in0..3      MMIO sources: button, x pos, y pos, colour
//   acc_been_read  sticky: core has read MMIO word 0
// ---------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                 DATA_W         = 16,
   parameter int                 CORE_AW        = 24,
   parameter int                 FB_AW          = 15,
   parameter logic [CORE_AW-1:0] MMIO_BASE      = 24'h00_8000,
   parameter int                 VGA_STREAK_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_arbiter_if.slave      bus,
   input  logic [DATA_W-1:0] io_in0,
   input  logic [DATA_W-1:0] io_in1,
   input  logic [DATA_W-1:0] io_in2,
   input  logic [DATA_W-1:0] io_in3,
   output logic              acc_been_read
);

   localparam int STREAK_W = $clog2(VGA_STREAK_MAX + 1);

   addr_class_e       w_class;
   logic              w_core_ram, w_core_nonram_rd, w_mmio;
   logic              w_streak_full, w_core_win, w_vga_win;
   logic [1:0]        w_offset;
   logic [DATA_W-1:0] w_io_rdata;
   logic              w_core_ram_ret, w_vga_ret;

   logic [STREAK_W-1:0] r_streak;
   logic                r_rd_pending;   // a RAM read was issued last cycle
   logic                r_owner_vga;    // ... and it belonged to VGA
   logic                r_core_io_rd;   // core non-RAM read issued last cycle
   logic [DATA_W-1:0]   r_core_hold;
   logic [DATA_W-1:0]   r_vga_hold;

   // ---------------- decode ----------------
   assign w_class          = addr_class(32'(bus.core_addr), FB_AW, 32'(MMIO_BASE));
   assign w_core_ram       = bus.core_req && (w_class == AC_RAM);
   assign w_mmio           = bus.core_req && (w_class == AC_MMIO);
   assign w_core_nonram_rd = bus.core_req && !bus.core_we && (w_class != AC_RAM);
   assign w_offset         = 2'(bus.core_addr - MMIO_BASE);

   // ---------------- arbitration ----------------
   // VGA wins contention until it has won VGA_STREAK_MAX contested cycles
   // in a row; then the core is forced through once.
   assign w_streak_full = (r_streak == STREAK_W'(VGA_STREAK_MAX));
   assign w_core_win    = w_core_ram && (!bus.vga_req || w_streak_full);
   assign w_vga_win     = bus.vga_req && !w_core_win;

   // Non-RAM core accesses never touch the RAM, so they are always granted.
   assign bus.core_gnt  = bus.core_req && (!w_core_ram || w_core_win);
   assign bus.vga_gnt   = w_vga_win;

   assign bus.mem_en    = w_core_win || w_vga_win;
   assign bus.mem_we    = w_core_win && bus.core_we;
   assign bus.mem_addr  = w_core_win ? bus.core_addr[FB_AW-1:0] : bus.vga_addr;
   assign bus.mem_wdata = bus.core_wdata;

   // NOTE: all state below uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_streak <= '0;
      else if (w_core_ram && w_vga_win && !w_streak_full)
         r_streak <= r_streak + 1'b1;
      else if (!(w_core_ram && w_vga_win))
         r_streak <= '0;
   end

   // ---------------- read return ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pending <= 1'b0;
         r_owner_vga  <= 1'b0;
         r_core_io_rd <= 1'b0;
      end else begin
         r_rd_pending <= bus.mem_en && !bus.mem_we;
         r_owner_vga  <= w_vga_win;
         r_core_io_rd <= w_core_nonram_rd;
      end
   end

   assign w_core_ram_ret = r_rd_pending && !r_owner_vga;
   assign w_vga_ret      = r_rd_pending &&  r_owner_vga;

   // RAM data is only valid in the return cycle, so it is passed straight
   // through then and captured into the hold register for later cycles.
   // A new MMIO/unmapped read overwrites the hold so its value shows next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_core_hold <= '0;
         r_vga_hold  <= '0;
      end else begin
         if (w_core_nonram_rd)
            r_core_hold <= (w_class == AC_MMIO) ? w_io_rdata : '0;
         else if (w_core_ram_ret)
            r_core_hold <= bus.mem_rdata;
         if (w_vga_ret)
            r_vga_hold <= bus.mem_rdata;
      end
   end

   assign bus.core_rvalid = w_core_ram_ret || r_core_io_rd;
   assign bus.core_rdata  = w_core_ram_ret ? bus.mem_rdata : r_core_hold;
   assign bus.vga_rvalid  = w_vga_ret;
   assign bus.vga_rdata   = w_vga_ret ? bus.mem_rdata : r_vga_hold;

   // ---------------- MMIO ----------------
   io_reg_bank #(.DATA_W(DATA_W)) u_io (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_io_in0 (io_in0),
      .i_io_in1 (io_in1),
      .i_io_in2 (io_in2),
      .i_io_in3 (io_in3),
      .i_rd     (w_mmio && !bus.core_we),
      .i_wr     (w_mmio && bus.core_we),
      .i_offset (w_offset),
      .o_rdata  (w_io_rdata),
      .o_acc    (acc_been_read)
   );

endmodule
